flappy_bird_control_sysid_sequencer: RTL

- Avalon-MM read master that owns the system ID slave (32-bit readdata; address 0 returns the system ID, address 1 returns the build timestamp).
- After reset, runs a boot check: reads both words, compares each against its parameter, and publishes match flags.
- After the boot check, shares the slave between two host requesters with round-robin arbitration.
- Sits between the sysid slave and the control/CPU-side logic.

---
 rtl/flappy_bird_control_sysid_sequencer_if.sv | 19 +
 rtl/flappy_bird_control_sysid_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/flappy_bird_control_sysid_sequencer_if.sv
// Avalon-MM read-only link between the sysid sequencer (master) and the
// system ID slave (address 0: system ID, address 1: build timestamp).
interface flappy_bird_control_sysid_sequencer_if;
    logic        sysid_address;
    logic        sysid_read;
    logic [31:0] sysid_readdata;

    modport master (
        output sysid_address,
        output sysid_read,
        input  sysid_readdata
    );

    modport slave (
        input  sysid_address,
        input  sysid_read,
        output sysid_readdata
    );
endinterface

// File: rtl/flappy_bird_control_sysid_sequencer.sv
// System ID sequencer: after reset reads the system ID and build timestamp,
// compares them with the expected values and publishes match flags, then
// shares the sysid slave between two host requesters (round-robin).
// Optional macro SYSID_RETRY_EN: on a boot mismatch, re-run the boot check
// up to MAX_RETRIES times before raising boot_done.
module flappy_bird_control_sysid_sequencer #(
    parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1480645824,
    parameter int unsigned READ_LATENCY       = 0,
    parameter int unsigned MAX_RETRIES        = 2
) (
    input  logic                                 clock,
    input  logic                                 reset,
    flappy_bird_control_sysid_sequencer_if.master sysid,
    input  logic                                 req0,
    input  logic                                 addr0,
    output logic                                 ack0,
    output logic [31:0]                          rdata0,
    input  logic                                 req1,
    input  logic                                 addr1,
    output logic                                 ack1,
    output logic [31:0]                          rdata1,
    output logic                                 boot_done,
    output logic                                 id_match,
    output logic                                 ts_match,
    output logic [31:0]                          ts_value
);

    localparam logic [1:0] LAT = 2'(READ_LATENCY);

    typedef enum logic [1:0] {
        BOOT_ID,
        BOOT_TS,
        IDLE,
        XFER
    } state_t;

    state_t      state_q, state_d;
    logic        busy_q, busy_d;        // read issued, waiting for sample edge
    logic        fin_q, fin_d;          // BOOT_TS compare done, boot_done next
    logic [1:0]  wcnt_q, wcnt_d;
    logic        last_grant_q, last_grant_d;
    logic        gnt_q, gnt_d;          // requester owning the XFER read
    logic [31:0] id_q, id_d;
    logic        rd_q, rd_d;
    logic        addr_q, addr_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        boot_done_q, boot_done_d;
    logic        id_match_q, id_match_d;
    logic        ts_match_q, ts_match_d;
    logic [31:0] ts_value_q, ts_value_d;

`ifdef SYSID_RETRY_EN
    localparam logic [1:0] RETRY_LIMIT = (MAX_RETRIES > 3) ? 2'd3 : 2'(MAX_RETRIES);
    logic [1:0] retry_q, retry_d;
`endif

    logic sample;
    logic elig0, elig1, pick1;

    assign sample = busy_q && (wcnt_q == LAT);
    // An ack still high means the host has not yet seen it drop its req.
    assign elig0  = req0 && !ack0_q;
    assign elig1  = req1 && !ack1_q;
    assign pick1  = elig1 && (!elig0 || !last_grant_q);

    // Next-state and registered-output computation for the sequencer FSM.
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        fin_d        = fin_q;
        wcnt_d       = wcnt_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        id_d         = id_q;
        rd_d         = rd_q;
        addr_d       = addr_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        boot_done_d  = boot_done_q;
        id_match_d   = id_match_q;
        ts_match_d   = ts_match_q;
        ts_value_d   = ts_value_q;
`ifdef SYSID_RETRY_EN
        retry_d      = retry_q;
`endif
        case (state_q)
            BOOT_ID: begin
                if (!busy_q) begin
                    rd_d   = 1'b1;
                    addr_d = 1'b0;
                    wcnt_d = '0;
                    busy_d = 1'b1;
                end else if (sample) begin
                    rd_d    = 1'b0;
                    busy_d  = 1'b0;
                    id_d    = sysid.sysid_readdata;
                    state_d = BOOT_TS;
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            BOOT_TS: begin
                if (fin_q) begin
                    fin_d = 1'b0;
`ifdef SYSID_RETRY_EN
                    if (!(id_match_q && ts_match_q) && (retry_q < RETRY_LIMIT)) begin
                        state_d = BOOT_ID;
                        if (retry_q != 2'b11) begin
                            retry_d = retry_q + 2'd1;
                        end
                    end else begin
                        boot_done_d = 1'b1;
                        state_d     = IDLE;
                    end
`else
                    boot_done_d = 1'b1;
                    state_d     = IDLE;
`endif
                end else if (!busy_q) begin
                    rd_d   = 1'b1;
                    addr_d = 1'b1;
                    wcnt_d = '0;
                    busy_d = 1'b1;
                end else if (sample) begin
                    rd_d       = 1'b0;
                    busy_d     = 1'b0;
                    fin_d      = 1'b1;
                    ts_value_d = sysid.sysid_readdata;
                    id_match_d = (id_q == EXPECTED_ID);
                    ts_match_d = (sysid.sysid_readdata == EXPECTED_TIMESTAMP);
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            IDLE: begin
                if (elig0 || elig1) begin
                    rd_d         = 1'b1;
                    addr_d       = pick1 ? addr1 : addr0;
                    wcnt_d       = '0;
                    busy_d       = 1'b1;
                    gnt_d        = pick1;
                    last_grant_d = pick1;
                    state_d      = XFER;
                end
            end
            XFER: begin
                if (sample) begin
                    rd_d    = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                    if (gnt_q) begin
                        ack1_d   = 1'b1;
                        rdata1_d = sysid.sysid_readdata;
                    end else begin
                        ack0_d   = 1'b1;
                        rdata0_d = sysid.sysid_readdata;
                    end
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            default: state_d = BOOT_ID;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= BOOT_ID;
            busy_q       <= 1'b0;
            fin_q        <= 1'b0;
            wcnt_q       <= '0;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            id_q         <= '0;
            rd_q         <= 1'b0;
            addr_q       <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            boot_done_q  <= 1'b0;
            id_match_q   <= 1'b0;
            ts_match_q   <= 1'b0;
            ts_value_q   <= '0;
`ifdef SYSID_RETRY_EN
            retry_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            fin_q        <= fin_d;
            wcnt_q       <= wcnt_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            id_q         <= id_d;
            rd_q         <= rd_d;
            addr_q       <= addr_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            boot_done_q  <= boot_done_d;
            id_match_q   <= id_match_d;
            ts_match_q   <= ts_match_d;
            ts_value_q   <= ts_value_d;
`ifdef SYSID_RETRY_EN
            retry_q      <= retry_d;
`endif
        end
    end

    assign sysid.sysid_read    = rd_q;
    assign sysid.sysid_address = addr_q;
    assign ack0                = ack0_q;
    assign ack1                = ack1_q;
    assign rdata0              = rdata0_q;
    assign rdata1              = rdata1_q;
    assign boot_done           = boot_done_q;
    assign id_match            = id_match_q;
    assign ts_match            = ts_match_q;
    assign ts_value            = ts_value_q;

endmodule
